tag_stream_engine: RTL and testbench

Streaming, key-programmable tag generator, and the parametrised successor of the single-word tag block. It absorbs a message of one or more DATA_SIZE-bit beats over a valid/ready handshake. Each beat is folded through per-block flip/rotate under a run-time loadable key and chained into a TAG_SIZE accumulator. One tag per message is presented on a valid/ready output port. It sits between the bus-side data mover and the tag checker.

---
 rtl/tag_stream_engine.sv | 145 ++++++++++++++
 tb/tb_tag_stream_engine.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tag_stream_engine.sv
// Streaming key-programmable tag generator: folds DATA_SIZE-bit beats into a TAG_SIZE accumulator.
// Optional macro TAG_LEN_MIX_EN mixes the saturating message beat count into the final tag.
module tag_stream_engine #(
    parameter int DATA_SIZE = 32,
    parameter int TAG_SIZE  = 8,
    parameter int CNT_W     = 16,
    parameter logic [(DATA_SIZE/TAG_SIZE)*(1+$clog2(TAG_SIZE))-1:0] KEY_INIT = 16'hDEAD
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   key_we,
    input  logic [(DATA_SIZE/TAG_SIZE)*(1+$clog2(TAG_SIZE))-1:0]   key_in,
    output logic                                                   key_err,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    input  logic [DATA_SIZE-1:0]                                   in_data,
    input  logic                                                   in_last,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic [TAG_SIZE-1:0]                                    tag,
    output logic                                                   busy
);
    localparam int NB       = DATA_SIZE / TAG_SIZE;
    localparam int RW       = $clog2(TAG_SIZE);
    localparam int KEY_SIZE = NB * (1 + RW);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the source holds payload stable while valid is high and ready is low.
    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

    state_t              state, state_next;
    logic [KEY_SIZE-1:0] key;
    logic [TAG_SIZE-1:0] acc;
    logic [TAG_SIZE-1:0] acc_next;
    logic [TAG_SIZE-1:0] fold;
    logic [TAG_SIZE-1:0] final_tag;
    logic [TAG_SIZE-1:0] blk;
    logic [RW:0]         fld;
    logic                msg_active;
    logic                beat;
    logic                tag_done;
    logic                key_ok;

    // Rotate left by r in [0, TAG_SIZE-1]; the doubled word avoids a shift by TAG_SIZE.
    function automatic logic [TAG_SIZE-1:0] rotl(input logic [TAG_SIZE-1:0] v,
                                                 input logic [RW-1:0] r);
        logic [2*TAG_SIZE-1:0] d;
        d = {v, v} << r;
        return d[2*TAG_SIZE-1:TAG_SIZE];
    endfunction

    always_comb begin
        fold = '0;
        fld  = '0;
        blk  = '0;
        for (int i = 0; i < NB; i++) begin
            fld = key[i*(1+RW) +: (1+RW)];
            blk = in_data[i*TAG_SIZE +: TAG_SIZE];
            if (fld[0]) blk = ~blk;
            fold = fold ^ rotl(blk, fld[RW:1]);
        end
    end

    assign acc_next = {acc[TAG_SIZE-2:0], acc[TAG_SIZE-1]} ^ fold;
    assign beat     = (state == ACC) && in_valid;
    assign tag_done = (state == HOLD) && out_ready;
    assign key_ok   = (state == ACC) && !msg_active;
    assign busy     = msg_active || (state == HOLD);

`ifdef TAG_LEN_MIX_EN
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic [TAG_SIZE-1:0] len_mix;

    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        len_mix = '0;
        for (int b = 0; b < TAG_SIZE && b < CNT_W; b++) len_mix[b] = cnt_inc[b];
    end

    assign final_tag = acc_next ^ len_mix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     cnt <= '0;
        else if (beat) cnt <= in_last ? '0 : cnt_inc;
    end
`else
    assign final_tag = acc_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ACC;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) state_next = ACC;
            end
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc        <= '0;
            msg_active <= 1'b0;
            tag        <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (beat) begin
                if (in_last) begin
                    tag        <= final_tag;
                    out_valid  <= 1'b1;
                    acc        <= '0;
                    msg_active <= 1'b0;
                end else begin
                    acc        <= acc_next;
                    msg_active <= 1'b1;
                end
            end
            if (tag_done) out_valid <= 1'b0;
        end
    end

    // The key may only change between messages; a beat on the same edge still sees the old key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key     <= KEY_INIT;
            key_err <= 1'b0;
        end else begin
            key_err <= key_we && !key_ok;
            if (key_we && key_ok) key <= key_in;
        end
    end

endmodule

// File: tb/tb_tag_stream_engine.sv
// Directed bench for tag_stream_engine (CNT_W reduced to 4); expectations follow TAG_LEN_MIX_EN.
module tb_tag_stream_engine;
`ifdef TAG_LEN_MIX_EN
    localparam bit MIX = 1'b1;
`else
    localparam bit MIX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_we = 1'b0;
    logic [15:0] key_in = '0;
    logic        key_err;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  tag;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    tag_stream_engine #(.DATA_SIZE(32), .TAG_SIZE(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .key_we(key_we), .key_in(key_in), .key_err(key_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .tag(tag), .busy(busy)
    );

    always #5 clk = ~clk;

    // Drivers: called #1 after a rising edge, return #1 after the next one.
    task automatic drive_beat(input logic [31:0] d, input logic last);
        in_valid = 1'b1; in_data = d; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drive_key(input logic [15:0] k);
        key_we = 1'b1; key_in = k;
        @(posedge clk); #1;
        key_we = 1'b0;
    endtask

    task automatic take_tag();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (key_err !== 1'b0) begin n_bad++; $display("FAIL reset_key_err: got %b want 0", key_err); end
        n_cmp++; if (tag !== 8'h00) begin n_bad++; $display("FAIL reset_tag: got %h want 00", tag); end
    endtask

    task automatic test_single_beat();
        drive_beat(32'h0000_00FF, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_ff_valid: got %b want 1", out_valid); end
        n_cmp++; if (tag !== (MIX ? 8'hFE : 8'hFF)) begin n_bad++; $display("FAIL single_ff_tag: got %h want %h", tag, MIX ? 8'hFE : 8'hFF); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL single_ff_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_ff_busy: got %b want 1", busy); end
        take_tag();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL single_ff_after: valid %b ready %b busy %b want 0 1 0", out_valid, in_ready, busy); end
        drive_beat(32'h0000_0001, 1'b1);
        n_cmp++; if (out_valid !== 1'b1 || tag !== (MIX ? 8'h41 : 8'h40)) begin
            n_bad++; $display("FAIL single_01_tag: valid %b tag %h want 1 %h", out_valid, tag, MIX ? 8'h41 : 8'h40); end
        take_tag();
    endtask

    task automatic test_two_beats();
        drive_beat(32'h0000_00FF, 1'b0);
        n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL two_mid: busy %b valid %b ready %b want 1 0 1", busy, out_valid, in_ready); end
        drive_beat(32'h0000_00FF, 1'b1);
        n_cmp++; if (out_valid !== 1'b1 || tag !== (MIX ? 8'h02 : 8'h00)) begin
            n_bad++; $display("FAIL two_tag: valid %b tag %h want 1 %h", out_valid, tag, MIX ? 8'h02 : 8'h00); end
        take_tag();
    endtask

    task automatic test_hold();
        drive_beat(32'h0000_00FF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || tag !== (MIX ? 8'hFE : 8'hFF)) begin
                n_bad++; $display("FAIL hold_cycle%0d: valid %b ready %b tag %h want 1 0 %h", i, out_valid, in_ready, tag, MIX ? 8'hFE : 8'hFF); end
            in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_last = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0; in_last = 1'b0;
        end
        take_tag();
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL hold_release: ready %b valid %b want 1 0", in_ready, out_valid); end
        drive_beat(32'h0000_0001, 1'b1);
        n_cmp++; if (out_valid !== 1'b1 || tag !== (MIX ? 8'h41 : 8'h40)) begin
            n_bad++; $display("FAIL back_to_back_tag: valid %b tag %h want 1 %h", out_valid, tag, MIX ? 8'h41 : 8'h40); end
        take_tag();
    endtask

    task automatic test_key_reject();
        drive_beat(32'h0000_00FF, 1'b0);
        drive_key(16'h0000);
        n_cmp++; if (key_err !== 1'b1) begin n_bad++; $display("FAIL key_reject_pulse: got %b want 1", key_err); end
        @(posedge clk); #1;
        n_cmp++; if (key_err !== 1'b0) begin n_bad++; $display("FAIL key_reject_clear: got %b want 0", key_err); end
        drive_beat(32'h0000_0001, 1'b1);
        n_cmp++; if (out_valid !== 1'b1 || tag !== (MIX ? 8'hBD : 8'hBF)) begin
            n_bad++; $display("FAIL key_reject_tag: valid %b tag %h want 1 %h", out_valid, tag, MIX ? 8'hBD : 8'hBF); end
        drive_key(16'h0000);
        n_cmp++; if (key_err !== 1'b1) begin n_bad++; $display("FAIL key_hold_pulse: got %b want 1", key_err); end
        take_tag();
    endtask

    task automatic test_key_write();
        drive_key(16'h0000);
        n_cmp++; if (key_err !== 1'b0) begin n_bad++; $display("FAIL key_write_err: got %b want 0", key_err); end
        drive_beat(32'h1234_5678, 1'b1);
        n_cmp++; if (out_valid !== 1'b1 || tag !== (MIX ? 8'h09 : 8'h08)) begin
            n_bad++; $display("FAIL key_zero_tag: valid %b tag %h want 1 %h", out_valid, tag, MIX ? 8'h09 : 8'h08); end
        take_tag();
        key_we = 1'b1; key_in = 16'hDEAD;
        drive_beat(32'h0000_0001, 1'b1);
        key_we = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || tag !== (MIX ? 8'h00 : 8'h01) || key_err !== 1'b0) begin
            n_bad++; $display("FAIL key_same_cycle: valid %b tag %h err %b want 1 %h 0", out_valid, tag, key_err, MIX ? 8'h00 : 8'h01); end
        take_tag();
        drive_beat(32'h0000_0001, 1'b1);
        n_cmp++; if (tag !== (MIX ? 8'h41 : 8'h40)) begin n_bad++; $display("FAIL key_restored_tag: got %h want %h", tag, MIX ? 8'h41 : 8'h40); end
        take_tag();
    endtask

    task automatic test_reset_mid();
        drive_key(16'h0000);
        for (int i = 0; i < 3; i++) drive_beat(32'hA5A5_0F0F, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", busy); end
        reset = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL mid_async_reset: busy %b ready %b valid %b want 0 1 0", busy, in_ready, out_valid); end
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        drive_beat(32'h0000_00FF, 1'b1);
        n_cmp++; if (out_valid !== 1'b1 || tag !== (MIX ? 8'hFE : 8'hFF)) begin
            n_bad++; $display("FAIL mid_after_tag: valid %b tag %h want 1 %h", out_valid, tag, MIX ? 8'hFE : 8'hFF); end
        take_tag();
        drive_beat(32'h0000_0001, 1'b1);
        n_cmp++; if (tag !== (MIX ? 8'h41 : 8'h40)) begin n_bad++; $display("FAIL mid_key_init: got %h want %h", tag, MIX ? 8'h41 : 8'h40); end
        take_tag();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 19; i++) drive_beat(32'h0000_00FF, 1'b0);
        drive_beat(32'h0000_00FF, 1'b1);
        n_cmp++; if (out_valid !== 1'b1 || tag !== (MIX ? 8'h0F : 8'h00)) begin
            n_bad++; $display("FAIL sat_tag: valid %b tag %h want 1 %h", out_valid, tag, MIX ? 8'h0F : 8'h00); end
        take_tag();
        n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL sat_idle: busy %b ready %b want 0 1", busy, in_ready); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_two_beats();
        test_hold();
        test_key_reject();
        test_key_write();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
